gate_response_checker: RTL and testbench
========================================

# gate_response_checker

Synthesizable response checker for the 4-input NOR gate block: the receiving end of the binary-count stimulus stream that drives inputs a–d.
- Takes each applied input vector and the DUT outputs e, f, g.
- Computes the expected outputs, aligns them to the DUT's sample latency and compares them.
- Counts vectors and mismatches over a fixed number of full 16-vector sweeps, then reports pass/fail.
- Sits beside the NOR gate on the bench and on-board self-test path, replacing waveform inspection.

## Interface
Parameters:
- LATENCY, 1, cycles between a vector on vec and the matching e/f/g; legal 0–3.
- SWEEPS, 1, number of full 16-vector sweeps checked per run; legal 1–15.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- vec_valid  in  1  vec is an applied stimulus this cycle.
- vec  in  4  stimulus {a,b,c,d}; a = vec[3].
- e, f, g  in  1 each  DUT outputs.
- busy  out  1  high in ARM and RUN.
- done  out  1  high in DONE.
- pass  out  1  valid while done: no mismatches (plus coverage, see Configuration).
- err_cnt  out  8  mismatch count, saturates at 255.
- chk_cnt  out  8  vectors compared this run.
- first_err_vec  out  4  vec of the first mismatch; 0 if none.

## Operation
- Expected values:
  - e_exp = ~(a|b)
  - f_exp = ~(c|d)
  - g_exp = e_exp & f_exp, which equals the 4-input NOR.
- A vector mismatches when any of e, f or g differs from its expected value. One mismatch counts once, regardless of how many bits differ.
- FSM states are IDLE, ARM, RUN, DONE.
  - IDLE -> ARM on start.
  - ARM clears the counters and flushes the delay line for LATENCY cycles, then goes to RUN. With LATENCY=0, ARM lasts exactly 1 cycle.
  - RUN: each vec_valid pushes {valid, vec, expected} into the delay line. When a valid entry emerges, it is compared against e/f/g and chk_cnt increments.
  - RUN -> DONE in the cycle after chk_cnt reaches 16·SWEEPS.
  - DONE holds all results. start returns the block to ARM; results clear on ARM entry.
- start is ignored in ARM and RUN.
- vec_valid is ignored outside RUN. Vectors still in flight when RUN exits are discarded.
- first_err_vec latches only on the first mismatch of a run.
- err_cnt stops at 255 and never wraps.

## Timing
- Reset values: busy=0, done=0, pass=0, err_cnt=0, chk_cnt=0, first_err_vec=0. State is IDLE and the delay line is cleared.
- Reset asserted mid-run overrides everything and returns the block to IDLE with the values above on the next edge.
- A vector is compared in the cycle where the DUT outputs are sampled: LATENCY cycles after the vec_valid edge. LATENCY=0 compares in the same cycle.
- Counter updates from a comparison are visible one cycle after the compare cycle.
- done and pass rise together, one cycle after the final counter update. pass is 0 whenever done is 0.
- A start pulse that arrives in the same cycle DONE is entered is ignored.

## Configuration
- CHECKER_COVERAGE_EN defined:
  - Adds a 16-bit seen mask, cleared in ARM, with bit vec set on each comparison.
  - pass also requires mask == 16'hFFFF.
  - Adds output cov_mask (out, 16).
- CHECKER_COVERAGE_EN undefined: no mask, no cov_mask port, and pass depends on err_cnt only.

## Structure
- Package checker_pkg holds:
  - the state enum (IDLE/ARM/RUN/DONE);
  - the VEC_W=4 and CNT_W=8 constants;
  - the function nor_expect(vec) returning {e_exp,f_exp,g_exp}.
- Sub-module expect_delay_line: a LATENCY-deep shift register of {valid, vec[3:0], exp[2:0]} with synchronous clear. At depth 0 it is a pass-through.
- The top level holds the FSM, counters and result latches.

## Test plan
- LATENCY=1, SWEEPS=1, correct DUT model, vec counting 0..15 one per cycle after start -> chk_cnt=16, err_cnt=0, done=1 and pass=1, both rising one cycle after the 16th counter update.
- Same setup with g forced to 0 -> mismatch only at vec=0 -> err_cnt=1, first_err_vec=4'h0, pass=0.
- Same setup with e inverted -> vectors 0–3 mismatch (e_exp=1) and vectors 4–15 mismatch (e_exp=0) -> err_cnt=16, first_err_vec=4'h0.
- SWEEPS=2, LATENCY=0, correct DUT; a start pulse mid-RUN -> start is ignored; done after chk_cnt=32, pass=1.
- rst pulsed after 7 comparisons with 2 errors -> all outputs return to reset values next cycle. A new start then counts from 0.
- With CHECKER_COVERAGE_EN, correct DUT, vec 3 never applied and 16 vectors sent (4 repeated) -> err_cnt=0, cov_mask=16'hFFF7, pass=0.

Source files
------------

// File: rtl/checker_pkg.sv
// Shared definitions for the 4-input NOR gate response checker.
//   - state_t    : checker FSM states (IDLE, ARM, RUN, DONE)
//   - VEC_W      : stimulus vector width ({a,b,c,d}, a = vec[3])
//   - CNT_W      : width of the vector and mismatch counters
//   - EXP_W      : width of the expected-output triple {e,f,g}
//   - ENTRY_W    : width of one delay-line entry {valid, vec, exp}
//   - nor_expect : expected {e,f,g} for a stimulus vector
package checker_pkg;

    localparam int VEC_W   = 4;
    localparam int CNT_W   = 8;
    localparam int EXP_W   = 3;
    localparam int ENTRY_W = 1 + VEC_W + EXP_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // e = NOR(a,b), f = NOR(c,d), g = e & f (the 4-input NOR).
    function automatic logic [EXP_W-1:0] nor_expect(input logic [VEC_W-1:0] v);
        logic e_exp;
        logic f_exp;
        e_exp = ~(v[3] | v[2]);
        f_exp = ~(v[1] | v[0]);
        return {e_exp, f_exp, e_exp & f_exp};
    endfunction

endpackage

// File: rtl/expect_delay_line.sv
// LATENCY-deep shift register that aligns {valid, vec, expected} with the
// gate outputs. At LATENCY = 0 it is a plain wire.
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset (clears all stages)
//   clr        : synchronous clear (flushes all stages)
//   push_entry : entry entering the line this cycle
//   pop_entry  : entry leaving the line this cycle
module expect_delay_line
    import checker_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [ENTRY_W-1:0] push_entry,
    output logic [ENTRY_W-1:0] pop_entry
);

    generate
        if (LATENCY == 0) begin : g_pass
            logic unused_ok;
            assign unused_ok = ^{clk, rst, clr};
            assign pop_entry = push_entry;
        end else begin : g_shift
            logic [ENTRY_W-1:0] stage [LATENCY];

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= push_entry;
                    for (int i = 1; i < LATENCY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign pop_entry = stage[LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/gate_response_checker.sv
// Response checker for the 4-input NOR gate block. Each applied vector is
// paired with its expected {e,f,g}, delayed by LATENCY cycles and compared
// with the gate outputs. A run checks 16*SWEEPS vectors and then reports.
// Optional feature macro: CHECKER_COVERAGE_EN (adds cov_mask, and pass also
// requires every one of the 16 vectors to have been compared).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : one-cycle pulse, begins a run from IDLE or DONE
//   vec_valid     : vec carries an applied stimulus this cycle
//   vec           : stimulus {a,b,c,d}
//   e, f, g       : gate outputs under check
//   busy          : high in ARM and RUN
//   done          : high in DONE
//   pass          : valid while done, no mismatches (and full coverage)
//   err_cnt       : mismatch count, saturating at 255
//   chk_cnt       : vectors compared this run
//   first_err_vec : vec of the first mismatch, 0 if none
//   cov_mask      : (CHECKER_COVERAGE_EN only) vectors seen this run
//   state         : current FSM state, for observation
// Handshake: vec_valid is a one-sided strobe with no back-pressure; a vector
// is consumed in every RUN cycle where vec_valid is high and is ignored in
// every other state.
module gate_response_checker
    import checker_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int SWEEPS  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vec_valid,
    input  logic [VEC_W-1:0] vec,
    input  logic             e,
    input  logic             f,
    input  logic             g,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [VEC_W-1:0] first_err_vec,
`ifdef CHECKER_COVERAGE_EN
    output logic [15:0]      cov_mask,
`endif
    output state_t           state
);

    localparam logic [CNT_W-1:0] RUN_TARGET = CNT_W'(16 * SWEEPS);
    // ARM needs at least one cycle even when there is nothing to flush.
    localparam int               ARM_CYC    = (LATENCY == 0) ? 1 : LATENCY;
    localparam logic [1:0]       ARM_LAST   = 2'(ARM_CYC - 1);

    state_t             state_q;
    state_t             state_d;
    logic               arm_entry;
    logic [1:0]         arm_cnt;

    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] pop_entry;
    logic               line_clr;
    logic               pop_valid;
    logic [VEC_W-1:0]   pop_vec;
    logic [EXP_W-1:0]   pop_exp;
    logic               compare;
    logic               mismatch;
    logic               clear_results;

    assign state = state_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        arm_entry = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ARM;
                    arm_entry = 1'b1;
                end
            end
            ARM: begin
                if (arm_cnt == ARM_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // chk_cnt already shows the final update here, so DONE
                // (and pass) appear one cycle after it.
                if (chk_cnt == RUN_TARGET) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d   = ARM;
                    arm_entry = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arm_cnt <= '0;
        end else if (state_q == ARM) begin
            arm_cnt <= arm_cnt + 2'd1;
        end else begin
            arm_cnt <= '0;
        end
    end

    // ---------------- Expected-value alignment ----------------
    assign push_entry = {vec_valid && (state_q == RUN), vec, nor_expect(vec)};
    // Holding the line clear outside RUN flushes it during ARM and drops
    // anything still in flight once RUN ends.
    assign line_clr   = (state_q != RUN);

    expect_delay_line #(
        .LATENCY (LATENCY)
    ) u_delay (
        .clk        (clk),
        .rst        (rst),
        .clr        (line_clr),
        .push_entry (push_entry),
        .pop_entry  (pop_entry)
    );

    assign pop_valid = pop_entry[ENTRY_W-1];
    assign pop_vec   = pop_entry[EXP_W +: VEC_W];
    assign pop_exp   = pop_entry[EXP_W-1:0];

    // Stop comparing once the run quota is reached; DONE follows next cycle.
    assign compare   = pop_valid && (state_q == RUN) && (chk_cnt != RUN_TARGET);
    assign mismatch  = (pop_exp != {e, f, g});

    assign clear_results = arm_entry || (state_q == ARM);

    // ---------------- Counters and result latches ----------------
    always_ff @(posedge clk) begin
        if (rst || clear_results) begin
            chk_cnt       <= '0;
            err_cnt       <= '0;
            first_err_vec <= '0;
        end else if (compare) begin
            chk_cnt <= chk_cnt + 1'b1;
            if (mismatch) begin
                if (err_cnt != {CNT_W{1'b1}}) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                // err_cnt never wraps, so zero means no mismatch yet.
                if (err_cnt == '0) begin
                    first_err_vec <= pop_vec;
                end
            end
        end
    end

`ifdef CHECKER_COVERAGE_EN
    logic [15:0] mask_q;

    always_ff @(posedge clk) begin
        if (rst || clear_results) begin
            mask_q <= '0;
        end else if (compare) begin
            mask_q <= mask_q | (16'b1 << pop_vec);
        end
    end

    assign cov_mask = mask_q;
    assign pass     = (state_q == DONE) && (err_cnt == '0) && (mask_q == 16'hFFFF);
`else
    assign pass     = (state_q == DONE) && (err_cnt == '0);
`endif

    assign busy = (state_q == ARM) || (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_gate_response_checker.sv
module tb_gate_response_checker;
    import checker_pkg::*;

    typedef struct packed {
        logic       pass;
        logic [7:0] err;
        logic [7:0] chk;
        logic [3:0] fev;
    } res_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT A: LATENCY=1, SWEEPS=1
    logic       start_a, vv_a, e_a, f_a, g_a;
    logic [3:0] vec_a;
    logic       busy_a, done_a, pass_a;
    logic [7:0] err_a, chk_a;
    logic [3:0] fev_a;
    state_t     st_a;
`ifdef CHECKER_COVERAGE_EN
    logic [15:0] cov_a;
`endif

    // DUT B: LATENCY=0, SWEEPS=2
    logic       start_b, vv_b, e_b, f_b, g_b;
    logic [3:0] vec_b;
    logic       busy_b, done_b, pass_b;
    logic [7:0] err_b, chk_b;
    logic [3:0] fev_b;
    state_t     st_b;
`ifdef CHECKER_COVERAGE_EN
    logic [15:0] cov_b;
`endif

    gate_response_checker #(.LATENCY(1), .SWEEPS(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .vec_valid(vv_a), .vec(vec_a),
        .e(e_a), .f(f_a), .g(g_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_cnt(err_a), .chk_cnt(chk_a), .first_err_vec(fev_a),
`ifdef CHECKER_COVERAGE_EN
        .cov_mask(cov_a),
`endif
        .state(st_a)
    );

    gate_response_checker #(.LATENCY(0), .SWEEPS(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .vec_valid(vv_b), .vec(vec_b),
        .e(e_b), .f(f_b), .g(g_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_cnt(err_b), .chk_cnt(chk_b), .first_err_vec(fev_b),
`ifdef CHECKER_COVERAGE_EN
        .cov_mask(cov_b),
`endif
        .state(st_b)
    );

    // ---------------- scoreboard ----------------
    logic [20:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    int          exp_chk;
    int          exp_err;
    logic [3:0]  exp_fev;
    logic [15:0] exp_mask;
    int          mode_a;
    logic [3:0]  prev_vec_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Gate model with optional planted faults:
    // 0 correct, 1 g stuck at 0, 2 e inverted, 3 g inverted on vec 2 and 5.
    function automatic logic [2:0] gate_model(input logic [3:0] v, input int mode);
        logic e, f, g;
        e = ~(v[3] | v[2]);
        f = ~(v[1] | v[0]);
        g = (v == 4'd0);
        case (mode)
            1: g = 1'b0;
            2: e = ~e;
            3: if (v == 4'd2 || v == 4'd5) g = ~g;
            default: ;
        endcase
        return {e, f, g};
    endfunction

    task automatic clear_expect();
        exp_chk  = 0;
        exp_err  = 0;
        exp_fev  = 4'd0;
        exp_mask = 16'd0;
    endtask

    task automatic account(input logic [3:0] v, input int mode);
        exp_chk++;
        exp_mask = exp_mask | (16'b1 << v);
        if (gate_model(v, mode) !== gate_model(v, 0)) begin
            if (exp_err == 0) exp_fev = v;
            if (exp_err < 255) exp_err++;
        end
    endtask

    task automatic push_expect();
        res_t r;
        r.chk  = 8'(exp_chk);
        r.err  = 8'(exp_err);
        r.fev  = exp_fev;
`ifdef CHECKER_COVERAGE_EN
        r.pass = (exp_err == 0) && (exp_mask == 16'hFFFF);
`else
        r.pass = (exp_err == 0);
`endif
        exp_q.push_back(r);
    endtask

    // ---------------- driver tasks (called at a negedge) ----------------
    // DUT A: gate outputs lag the vector by one cycle.
    task automatic drive_a(input logic valid, input logic [3:0] v);
        {e_a, f_a, g_a} = gate_model(prev_vec_a, mode_a);
        vv_a  = valid;
        vec_a = v;
        if (valid) account(v, mode_a);
        prev_vec_a = v;
        @(negedge clk);
    endtask

    // DUT B: gate outputs are combinational with the vector.
    task automatic drive_b(input logic valid, input logic [3:0] v);
        {e_b, f_b, g_b} = gate_model(v, 0);
        vv_b  = valid;
        vec_b = v;
        if (valid) account(v, 0);
        @(negedge clk);
    endtask

    task automatic wait_run_a();
        int n = 0;
        while (st_a != RUN && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("arm_to_run_a", 32'(st_a), 32'(RUN));
    endtask

    task automatic wait_run_b();
        int n = 0;
        while (st_b != RUN && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("arm_to_run_b", 32'(st_b), 32'(RUN));
    endtask

    task automatic start_a_pulse();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_run_a();
    endtask

    // Drives one full sweep; optionally replaces vec 3 by vec 4.
    task automatic run_a(input int mode, input logic skip3);
        mode_a = mode;
        clear_expect();
        start_a_pulse();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = (skip3 && i == 3) ? 4'd4 : 4'(i);
            drive_a(1'b1, v);
        end
        drive_a(1'b0, 4'd0);
        push_expect();
    endtask

    task automatic wait_done_a(output int lat);
        lat = 0;
        while (!done_a && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("done_a", 32'(done_a), 32'd1);
    endtask

    task automatic finish_a(input string tag);
        res_t r;
        int   lat;
        wait_done_a(lat);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            r = exp_q.pop_front();
            chk({tag, "_pass"}, 32'(pass_a), 32'(r.pass));
            chk({tag, "_err"},  32'(err_a),  32'(r.err));
            chk({tag, "_chk"},  32'(chk_a),  32'(r.chk));
            chk({tag, "_fev"},  32'(fev_a),  32'(r.fev));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   lat;
        res_t r;

        rst     = 1'b1;
        start_a = 1'b0; vv_a = 1'b0; vec_a = 4'd0; e_a = 1'b0; f_a = 1'b0; g_a = 1'b0;
        start_b = 1'b0; vv_b = 1'b0; vec_b = 4'd0; e_b = 1'b0; f_b = 1'b0; g_b = 1'b0;
        prev_vec_a = 4'd0;
        mode_a     = 0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy_a",  32'(busy_a), 32'd0);
        chk("rst_done_a",  32'(done_a), 32'd0);
        chk("rst_pass_a",  32'(pass_a), 32'd0);
        chk("rst_err_a",   32'(err_a),  32'd0);
        chk("rst_chk_a",   32'(chk_a),  32'd0);
        chk("rst_fev_a",   32'(fev_a),  32'd0);
        chk("rst_state_a", 32'(st_a),   32'(IDLE));
        chk("rst_state_b", 32'(st_b),   32'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Correct gate, full sweep, with done timing
        run_a(0, 1'b0);
        chk("t1_chk_before_done", 32'(chk_a), 32'd16);
        chk("t1_done_not_yet",    32'(done_a), 32'd0);
        wait_done_a(lat);
        chk("t1_done_latency", 32'(lat), 32'd1);
        r = exp_q.pop_front();
        chk("t1_pass", 32'(pass_a), 32'(r.pass));
        chk("t1_err",  32'(err_a),  32'(r.err));
        chk("t1_chk",  32'(chk_a),  32'(r.chk));
        chk("t1_fev",  32'(fev_a),  32'(r.fev));

        // g stuck at 0, then e inverted
        run_a(1, 1'b0);
        finish_a("t2");
        run_a(2, 1'b0);
        finish_a("t3");

        // Reset mid-run after 7 comparisons with 2 errors
        mode_a = 3;
        clear_expect();
        start_a_pulse();
        for (int i = 0; i < 7; i++) drive_a(1'b1, 4'(i));
        drive_a(1'b0, 4'd0);
        chk("t4_mid_chk", 32'(chk_a), 32'(exp_chk));
        chk("t4_mid_err", 32'(err_a), 32'(exp_err));
        chk("t4_mid_fev", 32'(fev_a), 32'(exp_fev));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_rst_busy",  32'(busy_a), 32'd0);
        chk("t4_rst_done",  32'(done_a), 32'd0);
        chk("t4_rst_err",   32'(err_a),  32'd0);
        chk("t4_rst_chk",   32'(chk_a),  32'd0);
        chk("t4_rst_fev",   32'(fev_a),  32'd0);
        chk("t4_rst_state", 32'(st_a),   32'(IDLE));
        run_a(0, 1'b0);
        finish_a("t4_rerun");

        // DUT B: two sweeps, zero latency, start pulse mid-run ignored
        clear_expect();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_run_b();
        for (int i = 0; i < 32; i++) begin
            start_b = (i == 10);
            drive_b(1'b1, 4'(i));
        end
        start_b = 1'b0;
        vv_b    = 1'b0;
        push_expect();
        lat = 0;
        while (!done_b && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("t5_done", 32'(done_b), 32'd1);
        chk("t5_done_latency", 32'(lat), 32'd1);
        r = exp_q.pop_front();
        chk("t5_pass", 32'(pass_b), 32'(r.pass));
        chk("t5_err",  32'(err_b),  32'(r.err));
        chk("t5_chk",  32'(chk_b),  32'(r.chk));

`ifdef CHECKER_COVERAGE_EN
        // Vec 3 never applied: clean but incomplete coverage
        run_a(0, 1'b1);
        finish_a("t6");
        chk("t6_cov", 32'(cov_a), 32'(exp_mask));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
